// File: rtl/cpu_types_pkg.sv
// Shared CPU types for branch prediction bookkeeping: word type, in-flight
// branch tag, resolver FSM states and the mispredict rule.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int BR_FIFO_DEPTH = 4;
  localparam int BR_IDX_W      = 2;

  // One in-flight predicted branch as recorded at fetch time.
  typedef struct packed {
    logic                taken;
    word_t               target;
    word_t               npc;
    logic [BR_IDX_W-1:0] index;
  } br_tag_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } br_state_t;

  // Wrong direction, or right direction (taken) but wrong target.
  function automatic logic br_mispredict(input br_tag_t head, input logic taken,
                                         input word_t target);
    return (head.taken != taken) ||
           (head.taken && taken && (head.target != target));
  endfunction

endpackage

// File: rtl/br_tag_fifo.sv
// Four-entry FIFO of in-flight branch tags. clear empties it in one edge and
// wins over push/pop; a push while full is only taken together with a pop.
module br_tag_fifo
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  br_tag_t    push_data,
  input  logic       pop,
  input  logic       clear,
  output logic       full,
  output logic       empty,
  output logic [2:0] count,
  output br_tag_t    head
);

  br_tag_t    mem_r [BR_FIFO_DEPTH];
  logic [1:0] rd_ptr_r;
  logic [1:0] wr_ptr_r;
  logic [2:0] count_r;
  logic       push_ok_s;
  logic       pop_ok_s;

  assign full      = (count_r == 3'(BR_FIFO_DEPTH));
  assign empty     = (count_r == 3'd0);
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Pointer and occupancy update; 2-bit pointers wrap modulo 4 naturally.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      rd_ptr_r <= 2'd0;
      wr_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 2'd1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 2'd1;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge CLK) begin
    if (push_ok_s && !clear) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/br_resolve.sv
// Branch resolution unit: tracks in-flight predictions, compares them with
// the execute-stage outcome, strobes a predictor update and, on mispredict,
// a flush/redirect followed by one RECOVER cycle in which inputs are ignored.
// Optional: define BR_RESOLVE_STATS_EN for saturating resolve/mispredict counters.
module br_resolve
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        push,
  input  logic        push_taken,
  input  word_t       push_target,
  input  word_t       push_npc,
  input  logic [1:0]  push_index,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  word_t       resolve_target,
  output logic        update_en,
  output logic        pr_correct,
  output word_t       update_br_target,
  output logic [1:0]  w_index,
  output logic        flush,
  output word_t       redirect_pc,
  output logic        full,
  output logic        empty,
  output logic [2:0]  count,
  output logic        err
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [15:0] resolved_cnt,
  output logic [15:0] mispredict_cnt
`endif
);

  br_state_t state_r;
  br_state_t state_next_s;
  br_tag_t   head_s;
  br_tag_t   push_tag_s;
  logic      in_run_s;
  logic      res_acc_s;
  logic      mis_s;
  logic      push_acc_s;
  logic      err_set_s;

  assign in_run_s   = (state_r == RUN);
  assign res_acc_s  = in_run_s && resolve_valid && !empty;
  assign mis_s      = res_acc_s && br_mispredict(head_s, resolve_taken, resolve_target);
  assign push_acc_s = in_run_s && push && !mis_s && (!full || res_acc_s);
  assign err_set_s  = in_run_s && ((push && full && !res_acc_s) ||
                                   (resolve_valid && empty));
  assign push_tag_s = '{taken: push_taken, target: push_target,
                        npc: push_npc, index: push_index};

  br_tag_fifo u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_acc_s),
    .push_data (push_tag_s),
    .pop       (res_acc_s && !mis_s),
    .clear     (mis_s),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head_s)
  );

  // Resolver state register.
  always_ff @(posedge CLK) begin
    if (RST) state_r <= RUN;
    else     state_r <= state_next_s;
  end

  // Next state: a mispredict costs exactly one RECOVER cycle.
  always_comb begin
    state_next_s = RUN;
    case (state_r)
      RUN: begin
        if (mis_s) state_next_s = RECOVER;
        else       state_next_s = RUN;
      end
      RECOVER: state_next_s = RUN;
      default: state_next_s = RUN;
    endcase
  end

  // Registered strobes and result data; data holds between resolves.
  always_ff @(posedge CLK) begin
    if (RST) begin
      update_en        <= 1'b0;
      pr_correct       <= 1'b0;
      flush            <= 1'b0;
      update_br_target <= 32'h0000_0000;
      w_index          <= 2'd0;
      redirect_pc      <= 32'h0000_0000;
      err              <= 1'b0;
    end else begin
      update_en  <= res_acc_s;
      pr_correct <= res_acc_s && !mis_s;
      flush      <= mis_s;
      if (res_acc_s) begin
        update_br_target <= resolve_target;
        w_index          <= head_s.index;
        redirect_pc      <= resolve_taken ? resolve_target : head_s.npc;
      end
      if (err_set_s) err <= 1'b1;
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      resolved_cnt   <= 16'd0;
      mispredict_cnt <= 16'd0;
    end else begin
      if (res_acc_s && (resolved_cnt != 16'hFFFF))
        resolved_cnt <= resolved_cnt + 16'd1;
      if (mis_s && (mispredict_cnt != 16'hFFFF))
        mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/br_resolve.md
BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 SHALL expose parameter none; depth fixed by package constant BR_FIFO_DEPTH = 4, index width 2.
REQ-002 CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 push  input  1  fetch issued a branch carrying a prediction.
REQ-005 push_taken  input  1  predictor's take_br for that branch.
REQ-006 push_target  input  word_t  predictor's br_target.
REQ-007 push_npc  input  word_t  fall-through PC (PC+4) of the branch.
REQ-008 push_index  input  2  predictor's out_index for the branch.
REQ-009 resolve_valid  input  1  execute stage resolved the oldest branch.
REQ-010 resolve_taken  input  1  actual branch outcome.
REQ-011 resolve_target  input  word_t  actual computed target.
REQ-012 update_en  output  1  one-cycle strobe: predictor update valid.
REQ-013 pr_correct  output  1  prediction matched outcome.
REQ-014 update_br_target  output  word_t  actual target for predictor.
REQ-015 w_index  output  2  predictor entry to update.
REQ-016 flush  output  1  one-cycle strobe: squash younger instructions.
REQ-017 redirect_pc  output  word_t  correct fetch PC, valid with flush.
REQ-018 full, empty  output  1 each  in-flight queue status.
REQ-019 count  output  3  in-flight entries, 0..4.
REQ-020 err  output  1  sticky protocol error flag.

Function
REQ-021 SHALL hold in-flight predictions in a 4-entry FIFO of {taken, target, npc, index}, push at tail, pop at head on resolve.
REQ-022 Mispredict SHALL be (head.taken != resolve_taken) or (both taken and head.target != resolve_target).
REQ-023 Outputs update_en, pr_correct, update_br_target, w_index, flush, redirect_pc SHALL be registered, valid exactly one cycle after the accepted resolve, deasserted otherwise (data outputs hold last value).
REQ-024 redirect_pc SHALL be resolve_target if resolve_taken else head.npc.
REQ-025 FSM states RUN, RECOVER; RUN -> RECOVER on accepted mispredicting resolve; RECOVER -> RUN unconditionally next cycle.
REQ-026 On mispredict edge SHALL clear the whole FIFO (younger entries squashed), including any simultaneous push.
REQ-027 In RECOVER, push and resolve_valid SHALL be ignored (no state change, no err).
REQ-028 Simultaneous push and correct resolve in RUN SHALL pop and push same edge; count unchanged; legal when full.
REQ-029 Push when full without simultaneous pop SHALL be dropped and set err.
REQ-030 resolve_valid when empty SHALL be ignored and set err; same-cycle push is not resolvable.
REQ-031 Pointers SHALL wrap modulo 4; count SHALL equal pushes minus pops, never exceeding 4.

Reset
REQ-032 RST SHALL force state RUN, FIFO empty, count 0, empty 1, full 0, err 0, update_en 0, flush 0, pr_correct 0, update_br_target 0, w_index 0, redirect_pc 0.
REQ-033 RST mid-operation SHALL discard all in-flight entries and any pending strobe; RST dominates push/resolve.

Configuration
REQ-034 With BR_RESOLVE_STATS_EN defined SHALL add outputs resolved_cnt and mispredict_cnt (16 bits, saturating, reset 0), incremented per accepted resolve / mispredict.
REQ-035 Without BR_RESOLVE_STATS_EN those ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-036 cpu_types_pkg SHALL hold br_tag_t struct {taken, target, npc, index} and BR_FIFO_DEPTH.
REQ-037 FIFO SHALL be sub-module br_tag_fifo (push, pop, clear, full, empty, count, head); FSM and compare in br_resolve.

Verification
REQ-038 Push {taken=1, target=0x100, idx=2}, resolve taken=1 target=0x100 -> next cycle update_en=1, pr_correct=1, w_index=2, flush=0.
REQ-039 Push {taken=0, npc=0x44, idx=1}, resolve taken=1 target=0x200 -> flush=1, redirect_pc=0x200, pr_correct=0, count=0; push next cycle ignored.
REQ-040 Push {taken=1, target=0x80, npc=0x14}, resolve taken=0 -> flush=1, redirect_pc=0x14.
REQ-041 Four pushes -> full=1; fifth push -> dropped, err=1; simultaneous push+correct resolve when full -> count stays 4, err unchanged.
REQ-042 resolve_valid with empty -> no strobe, err=1; RST with 3 entries -> count=0, err=0, no strobe.
